// File: rtl/reu_dma_engine_if.sv
// reu_dma_engine_if: CPU register port, C64 DMA slot and DRAM port of the REU engine.
// master = the engine, slave = the surrounding system (decoder, arbiter, SDRAM mux).
interface reu_dma_engine_if #(
   parameter int unsigned RAM_AW = 25
);
   logic [1:0]        size_sel;
   logic              cpu_cs;
   logic              cpu_we;
   logic [15:0]       cpu_addr;
   logic [7:0]        cpu_dout;
   logic [7:0]        cpu_din;
   logic              dma_req;
   logic              dma_cycle;
   logic [15:0]       dma_addr;
   logic [7:0]        dma_dout;
   logic [7:0]        dma_din;
   logic              dma_we;
   logic              ram_req;
   logic              ram_ack;
   logic [RAM_AW-1:0] ram_addr;
   logic [7:0]        ram_dout;
   logic [7:0]        ram_din;
   logic              ram_we;
   logic              irq;

   modport master (
      input  size_sel, cpu_cs, cpu_we, cpu_addr, cpu_dout, dma_cycle, dma_din, ram_ack, ram_din,
      output cpu_din, dma_req, dma_addr, dma_dout, dma_we, ram_req, ram_addr, ram_dout, ram_we, irq
   );

   modport slave (
      output size_sel, cpu_cs, cpu_we, cpu_addr, cpu_dout, dma_cycle, dma_din, ram_ack, ram_din,
      input  cpu_din, dma_req, dma_addr, dma_dout, dma_we, ram_req, ram_addr, ram_dout, ram_we, irq
   );
endinterface

// File: rtl/reu_dma_engine.sv
// reu_dma_engine: parametrised C64 RAM Expansion Unit DMA engine.
// Moves bytes between the C64 bus (DMA slot) and a DRAM window (req/ack).
// Optional feature macro: REU_SWAP_EN enables the swap transfer type (cmd[1:0]==2);
// without it a swap command completes at once with no DMA.
module reu_dma_engine #(
   parameter int unsigned       RAM_AW   = 25,
   parameter logic [RAM_AW-1:0] RAM_BASE = RAM_AW'(25'h400000),
   parameter int unsigned       MAX_LOG2 = 24,
   parameter int unsigned       C64_WAIT = 16
) (
   input  logic             clk,
   input  logic             reset,
   reu_dma_engine_if.master bus_if
);
   localparam int unsigned WAIT_W   = 5;
   localparam logic [23:0] MASK_MAX = 24'((33'd1 << MAX_LOG2) - 33'd1);

   typedef enum logic [1:0] {S_IDLE, S_EVAL, S_C64, S_RAM} state_t;

   state_t              state_q;
   logic [2:0]          step_q;
   logic [WAIT_W-1:0]   wait_q;
   logic                cs_q, we_q;
   logic [1:0]          status_q;
   logic [7:0]          cmd_q;
   logic [15:0]         c64_addr_q, sh_c64_q;
   logic [23:0]         reu_addr_q, sh_reu_q;
   logic [15:0]         len_q, sh_len_q;
   logic [2:0]          intr_q;
   logic [1:0]          ctl_q;
   logic [7:0]          c64_byte_q, ram_byte_q;
   logic [7:0]          cpu_din_q;
   logic                irq_q;
   logic                dma_req_q, dma_we_q;
   logic [15:0]         dma_addr_q;
   logic [7:0]          dma_dout_q;
   logic                ram_req_q, ram_we_q;
   logic [RAM_AW-1:0]   ram_addr_q;
   logic [7:0]          ram_dout_q;

   logic                rst_c;
   logic [23:0]         mask_c;
   logic                size_bit_c;
   logic                cs_rise_c;
   logic                ff00_wr_c;
   logic [1:0]          op_c;
   logic [2:0]          last_step_c;
   logic                acc_c64_c, acc_wr_c;
   logic                mismatch_c;
   logic [15:0]         c64_nxt_c;
   logic [23:0]         reu_nxt_c;
   logic [RAM_AW-1:0]   ram_addr_c;
   logic [7:0]          rd_data_c;

   // size_sel==0 parks the whole unit in reset
   assign rst_c      = reset | (bus_if.size_sel == 2'd0);
   assign size_bit_c = (bus_if.size_sel != 2'd1);
   assign cs_rise_c  = bus_if.cpu_cs & ~cs_q & ~dma_req_q;
   assign ff00_wr_c  = bus_if.cpu_we & ~we_q & (bus_if.cpu_addr == 16'hFF00);
   assign op_c       = cmd_q[1:0];
   assign mismatch_c = (op_c == 2'd3) && (c64_byte_q != ram_byte_q);
   assign c64_nxt_c  = ctl_q[1] ? c64_addr_q : c64_addr_q + 16'd1;
   assign reu_nxt_c  = ctl_q[0] ? reu_addr_q : ((reu_addr_q + 24'd1) & mask_c);
   assign ram_addr_c = RAM_BASE + RAM_AW'(reu_addr_q & mask_c);

   // REU address mask selected by the configured expansion size
   always_comb begin
      mask_c = MASK_MAX;
      case (bus_if.size_sel)
         2'd1:    mask_c = 24'h01FFFF;
         2'd2:    mask_c = 24'h07FFFF;
         default: mask_c = MASK_MAX;
      endcase
   end

   // per-byte access sequence: which bus the current step uses and its direction
   always_comb begin
      last_step_c = 3'd2;
      acc_c64_c   = 1'b0;
      acc_wr_c    = 1'b0;
      case (op_c)
         2'd0: begin  // stash: C64 read, RAM write
            acc_c64_c = (step_q == 3'd0);
            acc_wr_c  = (step_q == 3'd1);
         end
         2'd1: begin  // fetch: RAM read, C64 write
            acc_c64_c = (step_q == 3'd1);
            acc_wr_c  = (step_q == 3'd1);
         end
`ifdef REU_SWAP_EN
         2'd2: begin  // swap: C64 rd, RAM rd, C64 wr, RAM wr
            last_step_c = 3'd4;
            acc_c64_c   = ~step_q[0];
            acc_wr_c    = step_q[1];
         end
`endif
         default: begin  // verify: C64 read, RAM read
            acc_c64_c = (step_q == 3'd0);
            acc_wr_c  = 1'b0;
         end
      endcase
   end

   // register read multiplexer
   always_comb begin
      rd_data_c = 8'hFF;
      case (bus_if.cpu_addr[4:0])
         5'd0:    rd_data_c = {irq_q, status_q, size_bit_c, 4'h0};
         5'd1:    rd_data_c = cmd_q;
         5'd2:    rd_data_c = c64_addr_q[7:0];
         5'd3:    rd_data_c = c64_addr_q[15:8];
         5'd4:    rd_data_c = reu_addr_q[7:0];
         5'd5:    rd_data_c = reu_addr_q[15:8];
         5'd6:    rd_data_c = reu_addr_q[23:16] | ~mask_c[23:16];
         5'd7:    rd_data_c = len_q[7:0];
         5'd8:    rd_data_c = len_q[15:8];
         5'd9:    rd_data_c = {intr_q, 5'h1F};
         5'd10:   rd_data_c = {ctl_q, 6'h3F};
         default: rd_data_c = 8'hFF;
      endcase
   end

   // register file, transfer FSM and all registered outputs; FSM updates come last so
   // a terminate overrides a status clear in the same clock
   always_ff @(posedge clk) begin
      if (rst_c) begin
         state_q    <= S_IDLE;
         step_q     <= 3'd0;
         wait_q     <= '0;
         cs_q       <= 1'b0;
         we_q       <= 1'b0;
         status_q   <= 2'b00;
         cmd_q      <= 8'h10;
         c64_addr_q <= 16'h0000;
         reu_addr_q <= 24'h000000;
         len_q      <= 16'h0000;
         sh_c64_q   <= 16'h0000;
         sh_reu_q   <= 24'h000000;
         sh_len_q   <= 16'h0000;
         intr_q     <= 3'b000;
         ctl_q      <= 2'b00;
         c64_byte_q <= 8'h00;
         ram_byte_q <= 8'h00;
         cpu_din_q  <= 8'hFF;
         irq_q      <= 1'b0;
         dma_req_q  <= 1'b0;
         dma_we_q   <= 1'b0;
         dma_addr_q <= 16'h0000;
         dma_dout_q <= 8'h00;
         ram_req_q  <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_dout_q <= 8'h00;
      end else begin
         cs_q  <= bus_if.cpu_cs;
         we_q  <= bus_if.cpu_we;
         irq_q <= intr_q[2] & |(status_q & intr_q[1:0]);

         if (cs_rise_c) begin
            if (bus_if.cpu_we) begin
               case (bus_if.cpu_addr[4:0])
                  5'd1:  cmd_q <= bus_if.cpu_dout;
                  5'd2:  begin c64_addr_q[7:0]   <= bus_if.cpu_dout; sh_c64_q[7:0]   <= bus_if.cpu_dout; end
                  5'd3:  begin c64_addr_q[15:8]  <= bus_if.cpu_dout; sh_c64_q[15:8]  <= bus_if.cpu_dout; end
                  5'd4:  begin reu_addr_q[7:0]   <= bus_if.cpu_dout; sh_reu_q[7:0]   <= bus_if.cpu_dout; end
                  5'd5:  begin reu_addr_q[15:8]  <= bus_if.cpu_dout; sh_reu_q[15:8]  <= bus_if.cpu_dout; end
                  5'd6:  begin reu_addr_q[23:16] <= bus_if.cpu_dout; sh_reu_q[23:16] <= bus_if.cpu_dout; end
                  5'd7:  begin len_q[7:0]        <= bus_if.cpu_dout; sh_len_q[7:0]   <= bus_if.cpu_dout; end
                  5'd8:  begin len_q[15:8]       <= bus_if.cpu_dout; sh_len_q[15:8]  <= bus_if.cpu_dout; end
                  5'd9:  intr_q <= bus_if.cpu_dout[7:5];
                  5'd10: ctl_q  <= bus_if.cpu_dout[7:6];
                  default: ;
               endcase
            end else begin
               cpu_din_q <= rd_data_c;
               if (bus_if.cpu_addr[4:0] == 5'd0) status_q <= 2'b00;
            end
         end

         case (state_q)
            S_IDLE: begin
               if (cmd_q[7] & (cmd_q[4] | ff00_wr_c)) begin
`ifndef REU_SWAP_EN
                  if (op_c == 2'd2) begin
                     status_q[1] <= 1'b1;
                     cmd_q[7]    <= 1'b0;
                  end else
`endif
                  begin
                     state_q    <= S_EVAL;
                     step_q     <= 3'd0;
                     dma_req_q  <= 1'b1;
                     reu_addr_q <= reu_addr_q & mask_c;
                     sh_reu_q   <= sh_reu_q & mask_c;
                  end
               end
            end
            S_EVAL: begin
               if (step_q == last_step_c) begin
                  step_q <= 3'd0;
                  if ((len_q == 16'd1) || mismatch_c) begin
                     status_q  <= {1'b1, mismatch_c};
                     cmd_q[7]  <= 1'b0;
                     cmd_q[4]  <= 1'b1;
                     dma_req_q <= 1'b0;
                     state_q   <= S_IDLE;
                     if (cmd_q[5]) begin
                        c64_addr_q <= sh_c64_q;
                        reu_addr_q <= sh_reu_q;
                        len_q      <= sh_len_q;
                     end else begin
                        c64_addr_q <= c64_nxt_c;
                        reu_addr_q <= reu_nxt_c;
                        if (len_q != 16'd1) len_q <= len_q - 16'd1;
                     end
                  end else begin
                     c64_addr_q <= c64_nxt_c;
                     reu_addr_q <= reu_nxt_c;
                     len_q      <= len_q - 16'd1;
                  end
               end else if (acc_c64_c) begin
                  // start a C64 access only between bus slots
                  if (!bus_if.dma_cycle) begin
                     state_q    <= S_C64;
                     wait_q     <= '0;
                     dma_addr_q <= c64_addr_q;
                     dma_we_q   <= acc_wr_c;
                     dma_dout_q <= ram_byte_q;
                  end
               end else begin
                  state_q    <= S_RAM;
                  ram_req_q  <= 1'b1;
                  ram_we_q   <= acc_wr_c;
                  ram_addr_q <= ram_addr_c;
                  ram_dout_q <= c64_byte_q;
               end
            end
            S_C64: begin
               if (bus_if.dma_cycle) begin
                  if (wait_q == WAIT_W'(C64_WAIT - 1)) begin
                     if (!dma_we_q) c64_byte_q <= bus_if.dma_din;
                     dma_addr_q <= 16'h0000;
                     dma_we_q   <= 1'b0;
                     step_q     <= step_q + 3'd1;
                     state_q    <= S_EVAL;
                  end else begin
                     wait_q <= wait_q + WAIT_W'(1);
                  end
               end
            end
            S_RAM: begin
               if (bus_if.ram_ack) begin
                  if (!ram_we_q) ram_byte_q <= bus_if.ram_din;
                  ram_req_q <= 1'b0;
                  ram_we_q  <= 1'b0;
                  step_q    <= step_q + 3'd1;
                  state_q   <= S_EVAL;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus_if.cpu_din  = cpu_din_q;
   assign bus_if.irq      = irq_q;
   assign bus_if.dma_req  = dma_req_q;
   assign bus_if.dma_addr = dma_addr_q;
   assign bus_if.dma_dout = dma_dout_q;
   assign bus_if.dma_we   = dma_we_q & bus_if.dma_cycle;
   assign bus_if.ram_req  = ram_req_q;
   assign bus_if.ram_we   = ram_we_q;
   assign bus_if.ram_addr = ram_addr_q;
   assign bus_if.ram_dout = ram_dout_q;
endmodule
